// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/data requesters, the shared memory and the arbiter.
// The master modport is the arbiter's view; slave is the surrounding pipeline and memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              stall_f;
  logic              stall_d;
  logic              err;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
    output stall_f, stall_d, err
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_f, stall_d, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one shared single-port memory with variable latency,
// round-robin on conflict and a watchdog that aborts accesses that never complete.

module mem_port_arbiter_chk #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  input logic              if_ack,
  input logic              d_ack,
  input logic              err,
  input logic              mem_en,
  input logic              mem_we,
  input logic [ADDR_W-1:0] mem_addr,
  input logic [DATA_W-1:0] mem_wdata
);
  logic any_ack_s;
  assign any_ack_s = if_ack | d_ack;

  a_ack_excl: assert property (@(posedge clk) disable iff (rst) !(if_ack && d_ack));
  a_err_ack:  assert property (@(posedge clk) disable iff (rst) err |-> any_ack_s);
  a_ack_one:  assert property (@(posedge clk) disable iff (rst) any_ack_s |=> !any_ack_s);
  a_en_off:   assert property (@(posedge clk) disable iff (rst) any_ack_s |-> !mem_en);
  // Back-to-back strobe cycles always belong to one access, whose command must not move.
  a_hold:     assert property (@(posedge clk) disable iff (rst)
                (mem_en && $past(mem_en)) |->
                (mem_addr == $past(mem_addr) && mem_we == $past(mem_we) &&
                 mem_wdata == $past(mem_wdata)));
endmodule

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state_r,     state_s;
  logic              last_grant_r, last_grant_s;
  logic              grant_sel_r, grant_sel_s;
  logic [CW-1:0]     wait_cnt_r,  wait_cnt_s;
  logic              mem_en_r,    mem_en_s;
  logic              mem_we_r,    mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
  logic              if_ack_r,    if_ack_s;
  logic              d_ack_r,     d_ack_s;
  logic              err_r,       err_s;
  logic [DATA_W-1:0] if_rdata_r,  if_rdata_s;
  logic [DATA_W-1:0] d_rdata_r,   d_rdata_s;
  logic              pick_data_s;

  // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    grant_sel_s  = grant_sel_r;
    wait_cnt_s   = wait_cnt_r;
    mem_en_s     = mem_en_r;
    mem_we_s     = mem_we_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    if_ack_s     = 1'b0;
    d_ack_s      = 1'b0;
    err_s        = 1'b0;
    if_rdata_s   = if_rdata_r;
    d_rdata_s    = d_rdata_r;
    pick_data_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          // On conflict the port that did not win last time goes first.
          if (bus.d_req && (!bus.if_req || (last_grant_r == GRANT_FETCH))) begin
            pick_data_s = 1'b1;
          end else begin
            pick_data_s = 1'b0;
          end
          if (pick_data_s) begin
            mem_addr_s  = bus.d_addr;
            mem_we_s    = bus.d_we;
            mem_wdata_s = bus.d_wdata;
          end else begin
            mem_addr_s  = bus.if_addr;
            mem_we_s    = 1'b0;
            mem_wdata_s = '0;
          end
          grant_sel_s  = pick_data_s;
          last_grant_s = pick_data_s;
          mem_en_s     = 1'b1;
          wait_cnt_s   = '0;
          state_s      = ST_ACCESS;
        end else begin
          mem_en_s = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (bus.mem_ready && mem_en_r) begin
          mem_en_s = 1'b0;
          mem_we_s = 1'b0;
          state_s  = ST_RESP;
          if (grant_sel_r == GRANT_DATA) begin
            d_ack_s = 1'b1;
            if (!mem_we_r) begin
              d_rdata_s = bus.mem_rdata;
            end else begin
              d_rdata_s = d_rdata_r;
            end
          end else begin
            if_ack_s   = 1'b1;
            if_rdata_s = bus.mem_rdata;
          end
        end else if (wait_cnt_r == CNT_LAST) begin
          // Watchdog abort: complete the handshake with zero data and flag it.
          mem_en_s = 1'b0;
          mem_we_s = 1'b0;
          err_s    = 1'b1;
          state_s  = ST_RESP;
          if (grant_sel_r == GRANT_DATA) begin
            d_ack_s   = 1'b1;
            d_rdata_s = '0;
          end else begin
            if_ack_s   = 1'b1;
            if_rdata_s = '0;
          end
        end else begin
          wait_cnt_s = wait_cnt_r + CNT_ONE;
        end
      end

      ST_RESP: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s  = ST_IDLE;
        mem_en_s = 1'b0;
        mem_we_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= GRANT_FETCH;
      grant_sel_r  <= GRANT_FETCH;
      wait_cnt_r   <= '0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      if_ack_r     <= 1'b0;
      d_ack_r      <= 1'b0;
      err_r        <= 1'b0;
      if_rdata_r   <= '0;
      d_rdata_r    <= '0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      grant_sel_r  <= grant_sel_s;
      wait_cnt_r   <= wait_cnt_s;
      mem_en_r     <= mem_en_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      if_ack_r     <= if_ack_s;
      d_ack_r      <= d_ack_s;
      err_r        <= err_s;
      if_rdata_r   <= if_rdata_s;
      d_rdata_r    <= d_rdata_s;
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_ack    = if_ack_r;
  assign bus.d_ack     = d_ack_r;
  assign bus.err       = err_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  // Stalls follow the live request so the hazard unit sees them in the request cycle.
  assign bus.stall_f   = bus.if_req & ~if_ack_r;
  assign bus.stall_d   = bus.d_req & ~d_ack_r;

  mem_port_arbiter_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .if_ack    (if_ack_r),
    .d_ack     (d_ack_r),
    .err       (err_r),
    .mem_en    (mem_en_r),
    .mem_we    (mem_we_r),
    .mem_addr  (mem_addr_r),
    .mem_wdata (mem_wdata_r)
  );
endmodule
